// File: rtl/proc_csr_io.sv
// proc_csr_io: parametrised CSR I/O path.
// csrr reads are muxed in D and registered into X. csrw writes travel a
// PIPE_STAGES-deep squashable pipeline. At retirement they commit to the
// output registers and raise per-channel update, new and overflow flags.
// Optional macro CSR_IO_SYNC_EN adds a two-flop synchronizer on every
// in_data channel ahead of the read mux.
module proc_csr_io #(
    parameter  int DATA_W      = 32,
    parameter  int NUM_IN      = 3,
    parameter  int NUM_OUT     = 3,
    parameter  int PIPE_STAGES = 3,
    localparam int MAX_CH      = (NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT,
    localparam int SEL_W       = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]          rd_sel_D,
    output logic [DATA_W-1:0]         rd_data_X,
    input  logic                      wr_val_D,
    input  logic [SEL_W-1:0]          wr_sel_D,
    input  logic [DATA_W-1:0]         wr_data_D,
    input  logic [PIPE_STAGES-1:0]    squash,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_upd,
    output logic [NUM_OUT-1:0]        out_new,
    input  logic [NUM_OUT-1:0]        out_ack,
    output logic [NUM_OUT-1:0]        out_ovf,
    output logic                      wr_err
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [NUM_IN*DATA_W-1:0] rd_src;
    logic [DATA_W-1:0]        rd_mux;

    logic                     pipe_val  [PIPE_STAGES];
    logic [SEL_W-1:0]         pipe_sel  [PIPE_STAGES];
    logic [DATA_W-1:0]        pipe_data [PIPE_STAGES];

    logic [NUM_OUT-1:0]       commit_hit;
    logic                     commit_err;
    logic                     commit_val;

`ifdef CSR_IO_SYNC_EN
    logic [NUM_IN*DATA_W-1:0] sync_q1;
    logic [NUM_IN*DATA_W-1:0] sync_q2;

    // Two-flop synchronizer on every input channel
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_data;
            sync_q2 <= sync_q1;
        end
    end

    assign rd_src = sync_q2;
`else
    assign rd_src = in_data;
`endif

    // Read mux; out-of-range selects return zero
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(rd_sel_D) == i)
                rd_mux = rd_src[i*DATA_W +: DATA_W];
        end
    end

    // Read result register into X
    always_ff @(posedge clk) begin
        if (!rst)
            rd_data_X <= '0;
        else
            rd_data_X <= rd_mux;
    end

    // Write pipeline; squash[k] kills the entry held in register k
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                pipe_val[k]  <= 1'b0;
                pipe_sel[k]  <= '0;
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_val[0]  <= wr_val_D;
            pipe_sel[0]  <= wr_sel_D;
            pipe_data[0] <= wr_data_D;
            for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
                pipe_val[k]  <= pipe_val[k-1] & ~squash[k-1];
                pipe_sel[k]  <= pipe_sel[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    // Decode the retiring entry into a one-hot commit or an error
    always_comb begin
        commit_hit = '0;
        commit_val = pipe_val[LAST] & ~squash[LAST];
        for (int unsigned c = 0; c < NUM_OUT; c++) begin
            if (commit_val && (32'(pipe_sel[LAST]) == c))
                commit_hit[c] = 1'b1;
        end
        commit_err = commit_val & ~(|commit_hit);
    end

    // Output registers, pulses and sticky flags; commit beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data <= '0;
            out_upd  <= '0;
            out_new  <= '0;
            out_ovf  <= '0;
            wr_err   <= 1'b0;
        end else begin
            out_upd <= commit_hit;
            wr_err  <= commit_err;
            for (int unsigned c = 0; c < NUM_OUT; c++) begin
                if (commit_hit[c])
                    out_data[c*DATA_W +: DATA_W] <= pipe_data[LAST];
                out_new[c] <= commit_hit[c] | (out_new[c] & ~out_ack[c]);
                out_ovf[c] <= ~out_ack[c] & (out_ovf[c] | (commit_hit[c] & out_new[c]));
            end
        end
    end

endmodule

// File: tb/tb_proc_csr_io.sv
// Testbench for proc_csr_io (default parameters). Write commits are checked
// against a scoreboard queue filled at issue time; other checks are directed.
// Honours CSR_IO_SYNC_EN for the input latency check.
module tb_proc_csr_io;

    localparam int DW = 32;

    typedef struct {
        int unsigned ch;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [95:0]   in_data;
    logic [1:0]    rd_sel_D;
    logic [31:0]   rd_data_X;
    logic          wr_val_D;
    logic [1:0]    wr_sel_D;
    logic [31:0]   wr_data_D;
    logic [2:0]    squash;
    logic [95:0]   out_data;
    logic [2:0]    out_upd;
    logic [2:0]    out_new;
    logic [2:0]    out_ack;
    logic [2:0]    out_ovf;
    logic          wr_err;

    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;
    exp_t sb[$];
    logic [31:0] exp_mem [3];

    proc_csr_io #(.DATA_W(32), .NUM_IN(3), .NUM_OUT(3), .PIPE_STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .rd_sel_D  (rd_sel_D),
        .rd_data_X (rd_data_X),
        .wr_val_D  (wr_val_D),
        .wr_sel_D  (wr_sel_D),
        .wr_data_D (wr_data_D),
        .squash    (squash),
        .out_data  (out_data),
        .out_upd   (out_upd),
        .out_new   (out_new),
        .out_ack   (out_ack),
        .out_ovf   (out_ovf),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data, input bit expect_commit);
        exp_t e;
        wr_val_D  = 1'b1;
        wr_sel_D  = sel;
        wr_data_D = data;
        if (expect_commit) begin
            e.ch   = sel;
            e.data = data;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        wr_val_D  = 1'b0;
        wr_sel_D  = 2'd0;
        wr_data_D = 32'h0;
    endtask

    function automatic logic [95:0] model_out();
        return {exp_mem[2], exp_mem[1], exp_mem[0]};
    endfunction

    // Scoreboard monitor: every commit pulse pops the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wr_err === 1'b1)
                err_seen++;
            for (int c = 0; c < 3; c++) begin
                if (out_upd[c] === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_commit", 128'(out_upd), 128'(0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_channel", 128'(c), 128'(e.ch));
                        chk("sb_data", 128'(out_data[c*DW +: DW]), 128'(e.data));
                        exp_mem[c] = e.data;
                    end
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 3; c++) exp_mem[c] = 32'h0;
        rst       = 1'b0;
        in_data   = {32'h0000_CAFE, 32'h0000_00A5, 32'h0000_1234};
        rd_sel_D  = 2'd1;
        squash    = 3'b000;
        out_ack   = 3'b000;
        idle();
        tick();
        tick();

        // Reset state
        chk("rst_rd_data", 128'(rd_data_X), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_flags", 128'({out_upd, out_new, out_ovf, wr_err}), 128'(0));
        rst = 1'b1;
        tick();
        tick();
        tick();

        // Read path
        rd_sel_D = 2'd1; tick();
        chk("rd_ch1", 128'(rd_data_X), 128'(32'h0000_00A5));
        rd_sel_D = 2'd3; tick();
        chk("rd_out_of_range", 128'(rd_data_X), 128'(0));
        rd_sel_D = 2'd2; tick();
        chk("rd_ch2", 128'(rd_data_X), 128'(32'h0000_CAFE));
        rd_sel_D = 2'd0; tick();
        chk("rd_ch0", 128'(rd_data_X), 128'(32'h0000_1234));

        // Single write: 4-edge latency, then ack clears out_new
        wr(2'd2, 32'hDEAD_BEEF, 1'b1); tick();
        idle(); tick(); tick();
        chk("wr_not_yet", 128'(out_data), 128'(0));
        tick();
        chk("wr_data_ch2", 128'(out_data[2*DW +: DW]), 128'(32'hDEAD_BEEF));
        chk("wr_upd", 128'(out_upd), 128'(3'b100));
        chk("wr_new", 128'(out_new), 128'(3'b100));
        tick();
        chk("upd_pulse_end", 128'(out_upd), 128'(0));
        chk("new_sticky", 128'(out_new), 128'(3'b100));
        out_ack = 3'b100; tick();
        chk("ack_clears_new", 128'(out_new), 128'(0));
        out_ack = 3'b000;

        // Back-to-back writes to ch0 without ack -> overflow
        wr(2'd0, 32'h11, 1'b1); tick();
        wr(2'd0, 32'h22, 1'b1); tick();
        idle(); tick(); tick();
        chk("b2b_first", 128'(out_data[0 +: DW]), 128'(32'h11));
        chk("b2b_first_ovf", 128'({out_new[0], out_ovf[0]}), 128'(2'b10));
        tick();
        chk("b2b_second", 128'(out_data[0 +: DW]), 128'(32'h22));
        chk("b2b_ovf", 128'({out_new[0], out_ovf[0]}), 128'(2'b11));
        out_ack = 3'b001; tick();
        chk("ack_clears_both", 128'({out_new[0], out_ovf[0]}), 128'(2'b00));
        out_ack = 3'b000;

        // Commit and ack in the same cycle: new stays set, no overflow
        wr(2'd0, 32'h44, 1'b1); tick();
        wr(2'd0, 32'h66, 1'b1); tick();
        idle(); tick(); tick();
        chk("same_cyc_pre", 128'({out_new[0], out_ovf[0]}), 128'(2'b10));
        out_ack = 3'b001; tick();
        chk("same_cyc_flags", 128'({out_new[0], out_ovf[0]}), 128'(2'b10));
        chk("same_cyc_data", 128'(out_data[0 +: DW]), 128'(32'h66));
        tick();
        chk("same_cyc_cleared", 128'({out_new[0], out_ovf[0]}), 128'(2'b00));
        out_ack = 3'b000;

        // Squash while the entry sits in register 1
        wr(2'd1, 32'h55, 1'b0); tick();
        idle(); tick();
        squash = 3'b010; tick();
        squash = 3'b000; tick(); tick();
        chk("squash_out", 128'(out_data), 128'(model_out()));
        chk("squash_ch1", 128'(out_data[DW +: DW]), 128'(0));
        chk("squash_flags", 128'({out_upd, out_new[1], wr_err}), 128'(0));

        // Out-of-range write channel -> wr_err pulse, no register change
        wr(2'd3, 32'h77, 1'b0); tick();
        idle(); tick(); tick();
        chk("err_not_yet", 128'(wr_err), 128'(0));
        tick();
        chk("err_pulse", 128'(wr_err), 128'(1));
        chk("err_no_change", 128'(out_data), 128'(model_out()));
        chk("err_no_upd", 128'(out_upd), 128'(0));
        tick();
        chk("err_pulse_end", 128'(wr_err), 128'(0));

        // Reset mid-flight discards all pending writes
        wr(2'd0, 32'hA1, 1'b0); tick();
        wr(2'd1, 32'hA2, 1'b0); tick();
        wr(2'd2, 32'hA3, 1'b0); tick();
        idle();
        rst = 1'b0; tick();
        chk("midrst_out", 128'(out_data), 128'(0));
        chk("midrst_flags", 128'({out_upd, out_new, out_ovf, wr_err}), 128'(0));
        chk("midrst_rd", 128'(rd_data_X), 128'(0));
        for (int c = 0; c < 3; c++) exp_mem[c] = 32'h0;
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("postrst_no_upd", 128'({out_upd, wr_err}), 128'(0));
        end
        chk("postrst_out", 128'(out_data), 128'(0));

        // Input-change latency on rd_data_X
        rd_sel_D = 2'd0;
        tick();
        in_data[0 +: DW] = 32'hBEEF_0001;
        tick();
`ifdef CSR_IO_SYNC_EN
        chk("sync_lat1", 128'(rd_data_X), 128'(32'h0000_1234));
        tick();
        chk("sync_lat2", 128'(rd_data_X), 128'(32'h0000_1234));
        tick();
        chk("sync_lat3", 128'(rd_data_X), 128'(32'hBEEF_0001));
`else
        chk("in_lat1", 128'(rd_data_X), 128'(32'hBEEF_0001));
`endif

        tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));
        chk("err_pulse_count", 128'(err_seen), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_csr_io.md
Name: proc_csr_io

Overview:
- Parametrised successor of the TinyRV1 processor's CSR I/O path: NUM_IN read channels, NUM_OUT write channels, configurable pipeline depth.
- Reads (csrr) are muxed in D and registered into X.
- Writes (csrw) enter in D and travel a PIPE_STAGES-deep pipeline with per-stage squash. They commit to output registers at retirement and raise per-channel update flags that the consumer acknowledges.
- Replaces the fixed 3-in/3-out CSR logic inside the datapath.

Parameters:
- DATA_W, 32, width of every CSR data channel
- NUM_IN, 3, number of input CSR channels (>=1)
- NUM_OUT, 3, number of output CSR channels (>=1)
- PIPE_STAGES, 3, write pipeline registers between D and output commit (>=1)
- SEL_W derived: $clog2(max(NUM_IN,NUM_OUT)), minimum 1

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- in_data  input  NUM_IN*DATA_W  flattened input channels, channel i at [i*DATA_W +: DATA_W]
- rd_sel_D  input  SEL_W  read channel select in D
- rd_data_X  output  DATA_W  registered read result for X
- wr_val_D  input  1  write request in D
- wr_sel_D  input  SEL_W  destination output channel
- wr_data_D  input  DATA_W  write data (bypassed op1)
- squash  input  PIPE_STAGES  bit k kills the entry in pipeline register k
- out_data  output  NUM_OUT*DATA_W  flattened output registers
- out_upd  output  NUM_OUT  one-cycle pulse, channel committed this cycle
- out_new  output  NUM_OUT  sticky: unacknowledged data present
- out_ack  input  NUM_OUT  consumer acknowledge, clears out_new/out_ovf
- out_ovf  output  NUM_OUT  sticky: committed while out_new already set
- wr_err  output  1  one-cycle pulse, retired write had wr_sel_D >= NUM_OUT

Behaviour:
- Reset (rst==0 at posedge):
  - clears rd_data_X, all pipeline valid/sel/data, out_data, out_new, out_ovf.
  - out_upd and wr_err are registered pulses and are 0 after reset.
  - Reset mid-flight discards every in-flight write; no commit occurs.
- Read path:
  - rd_data_X <= in_data[rd_sel_D] every edge.
  - rd_sel_D >= NUM_IN yields 0.
  - Latency 1 edge; no handshake.
- Write pipeline:
  - Register 0 captures {wr_val_D, wr_sel_D, wr_data_D} every edge.
  - Register k captures register k-1 every edge.
  - Valid is forced 0 when squash[k-1] is high (or squash[0] for the entering entry's stage-0 successor). Squash therefore acts on the entry currently held in register k.
  - Sel and data advance regardless of valid.
- Commit, at each edge, from the last register (PIPE_STAGES-1) with valid=1 and squash[PIPE_STAGES-1]=0:
  - sel < NUM_OUT: out_data[sel] <= data; out_upd[sel] <= 1 for one cycle.
  - sel >= NUM_OUT: no register change; wr_err <= 1 for one cycle.
- Latency: a write asserted in D before edge t is visible on out_data after edge t+PIPE_STAGES. Default is 4 edges, matching the D->X->M->W->out timing.
- Back-to-back writes to the same channel commit in order, one per cycle.
- Flags per channel c:
  - out_new sets on commit to c and clears on out_ack[c].
  - Commit and ack in the same cycle: out_new stays 1 (commit wins) and out_ovf is not set.
  - out_ovf sets on commit while out_new=1 and out_ack[c]=0; clears on out_ack[c] alone.
  - Ack with out_new=0 has no effect.
- No stall input: the pipeline advances every cycle, and the controller expresses bubbles via wr_val_D=0 or squash.

Optional Feature:
- Macro: CSR_IO_SYNC_EN.
- Defined: each in_data channel passes through a two-flop synchronizer (reset 0) before the read mux. Read latency from in_data change to rd_data_X becomes 3 edges; rd_sel_D-to-rd_data_X stays 1 edge.
- Undefined: in_data feeds the mux directly; 1-edge latency, no extra flops.

Test Plan:
- Defaults; in_data ch1=0x0000_00A5, rd_sel_D=1 for one cycle -> rd_data_X=0x0000_00A5 after 1 edge. rd_sel_D=3 -> rd_data_X=0.
- wr_val_D=1, wr_sel_D=2, wr_data_D=0xDEAD_BEEF at cycle 0 -> out_data ch2=0xDEAD_BEEF, out_upd=3'b100 and out_new[2]=1 after edge 4. out_ack[2] at cycle 6 -> out_new[2]=0.
- Writes 0x11, 0x22 to ch0 on consecutive cycles, no ack -> ch0=0x11 then 0x22 on consecutive edges; out_ovf[0]=1 after the second commit. Ack clears both flags.
- Write ch1=0x55 with squash[1] pulsed when the entry is in register 1 -> out_data ch1 unchanged (0), no out_upd, no wr_err.
- wr_sel_D=3 (NUM_OUT=3), data 0x77 -> wr_err pulses once after edge 4; all out_data unchanged.
- Issue 3 writes, assert rst=0 for one cycle two edges later -> all outputs 0; no commits afterwards. With CSR_IO_SYNC_EN defined, an in_data ch0 change is seen on rd_data_X 3 edges later.
